// File: rtl/johnson_pkg.sv
`default_nettype none
// ============================================================================
// Module      : johnson_pkg
// Description : Shared defaults, index-width derivation and lock-state type
//               for the Johnson-code decoder.
// Revision    : 1.0 - initial release
// ============================================================================
package johnson_pkg;

  localparam int DEF_WIDTH    = 4;
  localparam int DEF_LOCK_CNT = 3;

  // Index width for a code of the given width (2*width states).
  function automatic int idx_width(input int width);
    return (width < 1) ? 1 : $clog2(2 * width);
  endfunction

  typedef enum logic [0:0] {
    ST_UNLOCK = 1'b0,
    ST_LOCKED = 1'b1
  } lock_state_t;

endpackage : johnson_pkg
`default_nettype wire

// File: rtl/johnson_code_chk.sv
`default_nettype none
// ============================================================================
// Module      : johnson_code_chk
// Description : Combinational legality check and index decode of one
//               Johnson code word.
// Revision    : 1.0 - initial release
// ============================================================================
module johnson_code_chk
  import johnson_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int IW    = idx_width(WIDTH)
) (
  input  logic [WIDTH-1:0] code_in,
  output logic             legal,
  output logic [IW-1:0]    idx
);

  localparam logic [IW-1:0] C_STATES_MOD = IW'(2 * WIDTH);

  logic          w_msb_run;
  logic          w_lsb_run;
  logic [IW-1:0] w_pop;

  always_comb begin
    w_msb_run = 1'b1;
    w_lsb_run = 1'b1;
    w_pop     = '0;
    // A 1 below a 0 breaks an MSB-anchored run; a 0 below a 1 breaks an LSB one.
    for (int i = 0; i < WIDTH - 1; i++) begin
      if (code_in[i] && !code_in[i+1]) w_msb_run = 1'b0;
      if (code_in[i+1] && !code_in[i]) w_lsb_run = 1'b0;
    end
    for (int i = 0; i < WIDTH; i++) begin
      w_pop = w_pop + IW'(code_in[i]);
    end
  end

  always_comb begin
    legal = w_msb_run | w_lsb_run;
    if (w_pop == '0) begin
      idx = '0;
    end else if (code_in[WIDTH-1]) begin
      idx = w_pop;
    end else begin
      // Modular subtraction gives 2*WIDTH - popcount without a wider datapath.
      idx = C_STATES_MOD - w_pop;
    end
  end

endmodule : johnson_code_chk
`default_nettype wire

// File: rtl/johnson_dec.sv
`default_nettype none
// ============================================================================
// Module      : johnson_dec
// Description : Registered Johnson-code decoder with step checking, lock
//               detection and a saturating error counter.
// Revision    : 1.0 - initial release
// ============================================================================
module johnson_dec
  import johnson_pkg::*;
#(
  parameter  int WIDTH    = DEF_WIDTH,
  parameter  int LOCK_CNT = DEF_LOCK_CNT,
  localparam int IW       = idx_width(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] code_in,
  input  logic             code_vld,
  output logic [IW-1:0]    idx,
  output logic             idx_vld,
  output logic             illegal,
  output logic             step_err,
  output logic             locked,
  output logic [7:0]       err_cnt
);

  localparam int            SCW        = $clog2(LOCK_CNT + 1);
  localparam logic [SCW-1:0] C_LOCK    = SCW'(LOCK_CNT);
  localparam logic [SCW-1:0] C_LOCK_M1 = SCW'(LOCK_CNT - 1);
  localparam logic [IW-1:0]  C_LAST    = IW'(2 * WIDTH - 1);

  logic              w_legal;
  logic [IW-1:0]     w_idx;
  logic [IW-1:0]     w_next_ref;
  logic              w_ill_ev;
  logic              w_checked;
  logic              w_step_ev;
  logic              w_good_step;
  logic              w_err_ev;

  logic [IW-1:0]     r_idx;
  logic              r_idx_vld;
  logic              r_illegal;
  logic              r_step_err;
  logic [IW-1:0]     r_ref_idx;
  logic              r_ref_ok;
  logic [7:0]        r_err_cnt;
  logic [SCW-1:0]    r_sc;
  lock_state_t       r_state;

  logic [SCW-1:0]    w_sc_nxt;
  lock_state_t       w_state_nxt;

  johnson_code_chk #(
    .WIDTH (WIDTH),
    .IW    (IW)
  ) u_chk (
    .code_in (code_in),
    .legal   (w_legal),
    .idx     (w_idx)
  );

  always_comb begin
    w_next_ref  = (r_ref_idx == C_LAST) ? '0 : r_ref_idx + 1'b1;
    w_ill_ev    = code_vld & ~w_legal;
    w_checked   = code_vld & w_legal & r_ref_ok;
    w_step_ev   = w_checked & (w_idx != w_next_ref);
    w_good_step = w_checked & ~w_step_ev;
    w_err_ev    = w_ill_ev | w_step_ev;
  end

  // Lock FSM next-state: sc holds LOCK_CNT while locked and is cleared on exit.
  always_comb begin
    w_state_nxt = r_state;
    w_sc_nxt    = r_sc;
    case (r_state)
      ST_UNLOCK: begin
        if (w_err_ev) begin
          w_sc_nxt = '0;
        end else if (w_good_step) begin
          if (r_sc >= C_LOCK_M1) begin
            w_sc_nxt    = C_LOCK;
            w_state_nxt = ST_LOCKED;
          end else begin
            w_sc_nxt = r_sc + 1'b1;
          end
        end
      end
      ST_LOCKED: begin
        if (w_err_ev) begin
          w_sc_nxt    = '0;
          w_state_nxt = ST_UNLOCK;
        end
      end
      default: begin
        w_sc_nxt    = '0;
        w_state_nxt = ST_UNLOCK;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_UNLOCK;
      r_sc    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_sc    <= w_sc_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx      <= '0;
      r_idx_vld  <= 1'b0;
      r_illegal  <= 1'b0;
      r_step_err <= 1'b0;
      r_ref_idx  <= '0;
      r_ref_ok   <= 1'b0;
      r_err_cnt  <= '0;
    end else begin
      r_idx_vld  <= code_vld & w_legal;
      r_illegal  <= w_ill_ev;
      r_step_err <= w_step_ev;
      // Every legal sample becomes the new reference, even one that failed the step check.
      if (code_vld && w_legal) begin
        r_idx     <= w_idx;
        r_ref_idx <= w_idx;
        r_ref_ok  <= 1'b1;
      end
      if (w_ill_ev) begin
        r_ref_ok <= 1'b0;
      end
      if (w_err_ev && (r_err_cnt != 8'hFF)) begin
        r_err_cnt <= r_err_cnt + 8'd1;
      end
    end
  end

  assign idx      = r_idx;
  assign idx_vld  = r_idx_vld;
  assign illegal  = r_illegal;
  assign step_err = r_step_err;
  assign locked   = (r_state == ST_LOCKED);
  assign err_cnt  = r_err_cnt;

endmodule : johnson_dec
`default_nettype wire

// File: tb/tb_johnson_dec.sv
`default_nettype none
// ============================================================================
// Module      : tb_johnson_dec
// Description : Self-checking bench for johnson_dec with directed scenarios
//               and a randomized run against a sequence-table reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_johnson_dec;

  localparam int W  = 4;
  localparam int LC = 3;
  localparam int IW = 3;
  localparam int NS = 2 * W;

  logic          clk = 1'b0;
  logic          rst;
  logic [W-1:0]  code_in;
  logic          code_vld;
  logic [IW-1:0] idx;
  logic          idx_vld;
  logic          illegal;
  logic          step_err;
  logic          locked;
  logic [7:0]    err_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model state
  logic [IW-1:0] m_idx;
  logic          m_vld, m_ill, m_se, m_locked;
  logic [7:0]    m_err;
  int            m_ref;
  logic          m_ref_ok;
  int            m_run;

  logic [IW+12:0] obs;
  logic [IW+12:0] exp_v;
  assign obs = {idx, idx_vld, illegal, step_err, locked, err_cnt};

  johnson_dec #(.WIDTH(W), .LOCK_CNT(LC)) dut (
    .clk      (clk),
    .rst      (rst),
    .code_in  (code_in),
    .code_vld (code_vld),
    .idx      (idx),
    .idx_vld  (idx_vld),
    .illegal  (illegal),
    .step_err (step_err),
    .locked   (locked),
    .err_cnt  (err_cnt)
  );

  always #5 clk = ~clk;

  // Legal codes are generated by walking the shift rule from all-zero.
  function automatic logic [W-1:0] idx_to_code(input int k);
    logic [W-1:0] s;
    s = '0;
    for (int i = 0; i < k; i++) s = {~s[0], s[W-1:1]};
    return s;
  endfunction

  function automatic int code_to_idx(input logic [W-1:0] c);
    for (int i = 0; i < NS; i++) begin
      if (idx_to_code(i) == c) return i;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_idx = '0; m_vld = 0; m_ill = 0; m_se = 0; m_locked = 0;
    m_err = '0; m_ref = 0; m_ref_ok = 0; m_run = 0;
    exp_v = {m_idx, m_vld, m_ill, m_se, m_locked, m_err};
  endtask

  task automatic do_reset();
    rst = 1'b1; code_vld = 1'b1; code_in = 4'b1000;
    @(posedge clk); #1;
    rst = 1'b0; code_vld = 1'b0;
    model_reset();
  endtask

  task automatic apply(input logic [W-1:0] c, input logic v);
    int k;
    code_in = c; code_vld = v;
    @(posedge clk); #1;
    code_vld = 1'b0;
    m_ill = 0; m_se = 0; m_vld = 0;
    if (v) begin
      k = code_to_idx(c);
      if (k < 0) begin
        m_ill = 1; m_ref_ok = 0; m_run = 0; m_locked = 0;
        if (m_err != 8'd255) m_err = m_err + 8'd1;
      end else begin
        m_vld = 1; m_idx = IW'(k);
        if (m_ref_ok) begin
          if (k != (m_ref + 1) % NS) begin
            m_se = 1; m_run = 0; m_locked = 0;
            if (m_err != 8'd255) m_err = m_err + 8'd1;
          end else begin
            m_run++;
            if (m_run >= LC) m_locked = 1;
          end
        end
        m_ref = k; m_ref_ok = 1;
      end
    end
    exp_v = {m_idx, m_vld, m_ill, m_se, m_locked, m_err};
  endtask

  task automatic test_reset();
    rst = 1'b1; code_vld = 1'b1; code_in = 4'b1100;
    @(posedge clk); #1;
    n_chk++;
    if (obs !== '0) begin
      n_fail++; $display("FAIL reset: got %h expected 0", obs);
    end
    rst = 1'b0; code_vld = 1'b0;
    model_reset();
  endtask

  task automatic test_sequence();
    do_reset();
    for (int i = 0; i < 10; i++) begin
      apply(idx_to_code(i % NS), 1'b1);
      n_chk++;
      if ({idx, idx_vld, illegal, step_err, locked, err_cnt} !==
          {IW'(i % NS), 1'b1, 1'b0, 1'b0, (i >= 3), 8'd0}) begin
        n_fail++;
        $display("FAIL sequence[%0d]: got idx=%0d vld=%b ill=%b se=%b lk=%b err=%0d", i,
                 idx, idx_vld, illegal, step_err, locked, err_cnt);
      end
    end
    apply(4'b0000, 1'b0);
    n_chk++;
    if ({idx_vld, illegal, step_err} !== 3'b000 || idx !== 3'd1) begin
      n_fail++; $display("FAIL idle_pulses: got vld=%b ill=%b se=%b idx=%0d expected 0 0 0 1",
                         idx_vld, illegal, step_err, idx);
    end
  endtask

  task automatic test_illegal();
    do_reset();
    apply(4'b1000, 1'b1);
    apply(4'b1100, 1'b1);
    apply(4'b1010, 1'b1);
    n_chk++;
    if ({illegal, idx_vld, idx, err_cnt, locked, step_err} !== {1'b1, 1'b0, 3'd2, 8'd1, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL illegal: got ill=%b vld=%b idx=%0d err=%0d lk=%b se=%b expected 1 0 2 1 0 0",
                         illegal, idx_vld, idx, err_cnt, locked, step_err);
    end
    apply(4'b1110, 1'b1);
    n_chk++;
    if ({illegal, step_err, idx, err_cnt} !== {1'b0, 1'b0, 3'd3, 8'd1}) begin
      n_fail++; $display("FAIL after_illegal_nocheck: got ill=%b se=%b idx=%0d err=%0d expected 0 0 3 1",
                         illegal, step_err, idx, err_cnt);
    end
  endtask

  task automatic test_step_err();
    do_reset();
    apply(4'b1000, 1'b1);
    apply(4'b1100, 1'b1);
    apply(4'b0111, 1'b1);
    n_chk++;
    if ({step_err, illegal, idx, err_cnt} !== {1'b1, 1'b0, 3'd5, 8'd1}) begin
      n_fail++; $display("FAIL step_err: got se=%b ill=%b idx=%0d err=%0d expected 1 0 5 1",
                         step_err, illegal, idx, err_cnt);
    end
    apply(4'b0011, 1'b1);
    n_chk++;
    if ({step_err, idx, err_cnt} !== {1'b0, 3'd6, 8'd1}) begin
      n_fail++; $display("FAIL step_after_err: got se=%b idx=%0d err=%0d expected 0 6 1",
                         step_err, idx, err_cnt);
    end
  endtask

  task automatic test_repeat();
    do_reset();
    apply(4'b0000, 1'b1);
    apply(4'b1000, 1'b1);
    apply(4'b1100, 1'b1);
    apply(4'b1110, 1'b1);
    n_chk++;
    if (locked !== 1'b1) begin
      n_fail++; $display("FAIL lock_before_repeat: got %b expected 1", locked);
    end
    apply(4'b1110, 1'b1);
    n_chk++;
    if ({step_err, locked, err_cnt, idx} !== {1'b1, 1'b0, 8'd1, 3'd3}) begin
      n_fail++; $display("FAIL repeat: got se=%b lk=%b err=%0d idx=%0d expected 1 0 1 3",
                         step_err, locked, err_cnt, idx);
    end
    apply(4'b1111, 1'b1);
    n_chk++;
    if ({step_err, locked, err_cnt, idx} !== {1'b0, 1'b0, 8'd1, 3'd4}) begin
      n_fail++; $display("FAIL after_repeat: got se=%b lk=%b err=%0d idx=%0d expected 0 0 1 4",
                         step_err, locked, err_cnt, idx);
    end
  endtask

  task automatic test_saturate();
    do_reset();
    for (int i = 0; i < 300; i++) begin
      apply(4'b0101, 1'b1);
      if (i == 253) begin
        n_chk++;
        if (err_cnt !== 8'd254) begin
          n_fail++; $display("FAIL err_cnt_254: got %0d expected 254", err_cnt);
        end
      end
    end
    n_chk++;
    if ({err_cnt, illegal, idx_vld} !== {8'd255, 1'b1, 1'b0}) begin
      n_fail++; $display("FAIL saturate: got err=%0d ill=%b vld=%b expected 255 1 0",
                         err_cnt, illegal, idx_vld);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 5; i++) apply(4'b1001, 1'b1);
    for (int i = 0; i < 4; i++) apply(idx_to_code(i), 1'b1);
    n_chk++;
    if ({locked, err_cnt} !== {1'b1, 8'd5}) begin
      n_fail++; $display("FAIL pre_reset: got lk=%b err=%0d expected 1 5", locked, err_cnt);
    end
    rst = 1'b1; code_vld = 1'b1; code_in = 4'b1111;
    @(posedge clk); #1;
    rst = 1'b0; code_vld = 1'b0;
    model_reset();
    n_chk++;
    if (obs !== '0) begin
      n_fail++; $display("FAIL mid_reset: got %h expected 0", obs);
    end
    apply(4'b0111, 1'b1);
    n_chk++;
    if ({idx, idx_vld, step_err, illegal, err_cnt, locked} !== {3'd5, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0}) begin
      n_fail++; $display("FAIL first_after_reset: got idx=%0d vld=%b se=%b ill=%b err=%0d lk=%b",
                         idx, idx_vld, step_err, illegal, err_cnt, locked);
    end
  endtask

  task automatic test_random();
    int cur;
    int r;
    logic [W-1:0] c;
    do_reset();
    cur = 0;
    for (int n = 0; n < 600; n++) begin
      r = $urandom_range(0, 15);
      if ($urandom_range(0, 99) == 0) begin
        do_reset();
      end else if (r == 0) begin
        c = W'($urandom);
        apply(c, 1'b1);
        if (code_to_idx(c) >= 0) cur = code_to_idx(c);
      end else if (r == 1) begin
        apply(idx_to_code(cur), 1'b1);
      end else if (r == 2) begin
        apply(W'($urandom), 1'b0);
      end else if (r == 3) begin
        cur = $urandom_range(0, NS - 1);
        apply(idx_to_code(cur), 1'b1);
      end else begin
        cur = (cur + 1) % NS;
        apply(idx_to_code(cur), 1'b1);
      end
      n_chk++;
      if (obs !== exp_v) begin
        n_fail++; $display("FAIL random[%0d]: got %h expected %h", n, obs, exp_v);
      end
    end
  endtask

  initial begin
    rst = 1'b1; code_vld = 1'b0; code_in = '0;
    model_reset();
    @(posedge clk); #1;
    test_reset();
    test_sequence();
    test_illegal();
    test_step_err();
    test_repeat();
    test_saturate();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule : tb_johnson_dec
`default_nettype wire

// File: doc/johnson_dec.md
JOHNSON_DEC -- requirements
Module: johnson_dec

Interface
REQ-001 Parameter WIDTH, default 4: Johnson code width; the code has 2*WIDTH states.
REQ-002 Parameter LOCK_CNT, default 3: number of consecutive correct steps needed to assert locked.
REQ-003 Port clk, input, 1: single clock; all logic on its rising edge.
REQ-004 Port rst, input, 1: synchronous, active-high reset.
REQ-005 Port code_in, input, WIDTH: Johnson code sampled from the counter under observation.
REQ-006 Port code_vld, input, 1: code_in is sampled on this cycle.
REQ-007 Port idx, output, IW = clog2(2*WIDTH): decoded state index.
REQ-008 Port idx_vld, output, 1: idx is valid.
REQ-009 Port illegal, output, 1: the last sample was not a legal Johnson code.
REQ-010 Port step_err, output, 1: the last legal sample was not the successor of the previous legal sample.
REQ-011 Port locked, output, 1: lock FSM is in state LOCKED.
REQ-012 Port err_cnt, output, 8: saturating error count.

Function
REQ-013 The code sequence SHALL be 0000, 1000, 1100, 1110, 1111, 0111, 0011, 0001 (WIDTH=4), mapping to indices 0..7: shift right, with the inverted LSB entering the MSB.
REQ-014 A code SHALL be legal iff its ones form one contiguous run anchored at the MSB or at the LSB; all-zero and all-one are legal.
REQ-015 Index rule: all-zero maps to 0; if the MSB is 1, idx = popcount; otherwise idx = 2*WIDTH - popcount.
REQ-016 Latency SHALL be 1 cycle: a sample with code_vld=1 at edge N drives idx, idx_vld, illegal and step_err after edge N+1.
REQ-017 idx_vld SHALL be 1 only for a legal sample; on an illegal sample, idx holds its previous value and illegal=1.
REQ-018 illegal and step_err SHALL be single-cycle pulses; all pulse outputs are 0 on cycles following code_vld=0.
REQ-019 The block SHALL hold a reference index (ref_idx) and a flag ref_ok; ref_ok is cleared by reset and by any illegal sample.
REQ-020 For a legal sample with ref_ok=1, step_err SHALL be 1 iff idx != (ref_idx+1) mod 2*WIDTH, so that 7->0 is a correct wrap.
REQ-021 For a legal sample with ref_ok=0, no step check SHALL occur; the sample loads ref_idx and sets ref_ok.
REQ-022 An illegal sample SHALL take precedence: no step check is made and err_cnt increments exactly once.
REQ-023 err_cnt SHALL increment by 1 on each illegal or step_err event and saturate at 255.
REQ-024 Lock FSM states SHALL be UNLOCK and LOCKED, with a step counter sc sized to hold LOCK_CNT.
REQ-025 In UNLOCK, each correct checked step SHALL increment sc; when sc reaches LOCK_CNT the FSM goes to LOCKED.
REQ-026 In UNLOCK, an illegal sample or step_err SHALL clear sc.
REQ-027 In LOCKED, an illegal sample or step_err SHALL return the FSM to UNLOCK with sc=0.
REQ-028 A repeated index (no advance) SHALL count as a step_err.

Reset
REQ-029 When rst=1 at an edge, the following SHALL be 0 after that edge: idx, idx_vld, illegal, step_err, locked, err_cnt, sc, ref_idx, ref_ok; the FSM goes to UNLOCK.
REQ-030 Reset SHALL dominate code_vld on the same edge; a reset asserted mid-sequence discards all history.

Structure
REQ-031 Package johnson_pkg SHALL hold the default WIDTH, the IW derivation and the lock-state enum.
REQ-032 Sub-module johnson_code_chk SHALL be purely combinational: code_in in; legal and idx out.
REQ-033 All registers, the FSM and err_cnt SHALL reside in johnson_dec.

Verification
REQ-034 Reset released, then 10 consecutive legal codes from 0000 -> idx = 0..7,0,1; no errors; locked rises 1 cycle after the 4th sample (3rd checked step).
REQ-035 Sequence 1000,1100,1010 -> third sample gives illegal=1, idx holds 2, err_cnt=1, locked=0.
REQ-036 Sequence 1000,1100,0111 -> step_err=1 on the third sample, err_cnt=1; the next sample 0011 is checked against 5 with no error.
REQ-037 Lock, then inject 1111 after 1110,1110 -> repeat flags step_err, locked drops to 0, err_cnt=1.
REQ-038 Inject 300 illegal codes (0101) -> err_cnt saturates at 255.
REQ-039 Assert rst for 1 cycle while locked with err_cnt=5 -> all outputs 0 next cycle; the first legal sample afterwards is not step-checked.
